// File: rtl/storage_pkg.sv
// Shared types and widths for the SRAM storage controller.
// Widths describe the 2048x32 macro this controller fronts.
package storage_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/storage_rsp_fifo.sv
// Small synchronous FIFO holding read data until the consumer takes it.
// Output is read straight from storage, so data shows up the cycle after a push.
module storage_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is accepted when the same edge pops an entry.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sram_storage_ctrl.sv
// Request/response front-end for a single-port 2048x32 SRAM macro.
// Handshakes: a transfer happens on any posedge where valid && ready; ready never depends on valid.
module sram_storage_ctrl #(
    parameter int         ADDR_W    = 11,
    parameter int         DATA_W    = 32,
    parameter logic [2:0] EMA_VAL   = 3'b000,
    parameter int         RSP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_d,
    output logic [2:0]            sram_ema,
    output logic                  sram_retn,
    input  logic [DATA_W-1:0]     sram_q,
    output logic [1:0]            dbg_state
);
    import storage_pkg::*;

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    ctrl_state_e       state;
    ctrl_state_e       state_nxt;
    mem_req_t          rmw_q;
    logic              rd_inflight;
    logic              accept_rd;
    logic              start_rmw;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              rsp_pop;
    logic [CNT_W:0]    occupancy;
    logic              rd_slot_free;

    assign sram_ema  = EMA_VAL;
    assign sram_retn = 1'b1;
    assign dbg_state = state;

    assign rsp_valid = !fifo_empty && !rst;
    assign rsp_rdata = fifo_rdata;
    assign rsp_pop   = rsp_valid && rsp_ready;

    // Slots committed after this edge: stored words plus the read in flight, less the word
    // leaving now. Crediting the pop is what lets reads stream at one per cycle.
    assign occupancy    = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(rd_inflight) - (CNT_W+1)'(rsp_pop);
    assign rd_slot_free = occupancy < (CNT_W+1)'(RSP_DEPTH);

    always_comb begin
        merged = sram_q;
        for (int b = 0; b < BE_W; b++) begin
            if (rmw_q.be[b]) begin
                merged[b*8 +: 8] = rmw_q.wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_addr = req_addr;
        sram_d    = req_wdata;
        accept_rd = 1'b0;
        start_rmw = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    req_ready = req_we ? 1'b1 : rd_slot_free;
                    if (req_valid && req_ready) begin
                        if (!req_we) begin
                            sram_cen  = 1'b0;
                            accept_rd = 1'b1;
                        end else if (&req_be) begin
                            sram_cen = 1'b0;
                            sram_wen = 1'b0;
                        end else if (|req_be) begin
                            sram_cen  = 1'b0;
                            start_rmw = 1'b1;
                            state_nxt = RMW_RD;
                        end
                    end
                end
                RMW_RD: begin
                    // Old word is on sram_q now; write back the byte merge.
                    sram_cen  = 1'b0;
                    sram_wen  = !rmw_q.we;
                    sram_addr = rmw_q.addr;
                    sram_d    = merged;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_inflight <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_inflight <= accept_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (start_rmw) begin
            rmw_q <= '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (state != RMW_WR);
            assert (!(fifo_full && rd_inflight && !rsp_pop));
        end
    end

    storage_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_inflight),
        .push_data (sram_q),
        .pop       (rsp_pop),
        .pop_data  (fifo_rdata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_sram_storage_ctrl.sv
// Bench for sram_storage_ctrl: macro model, request-level reference memory,
// response scoreboard, directed vectors and a randomized traffic phase.
module tb_sram_storage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        sram_cen;
    logic        sram_wen;
    logic [10:0] sram_addr;
    logic [31:0] sram_d;
    logic [2:0]  sram_ema;
    logic        sram_retn;
    logic [31:0] sram_q;
    logic [1:0]  dbg_state;

    sram_storage_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_d    (sram_d),
        .sram_ema  (sram_ema),
        .sram_retn (sram_retn),
        .sram_q    (sram_q),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM macro: 1-cycle read latency, Q holds between reads.
    logic [31:0] macro_mem [2048];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) macro_mem[sram_addr] <= sram_d;
            else           sram_q <= macro_mem[sram_addr];
        end
    end

    // rsp_ready is driven only here: 0 = hold low, 1 = hold high, 2 = random.
    int rsp_mode = 1;
    always @(posedge clk) begin
        #2;
        rsp_ready = (rsp_mode == 2) ? 1'($urandom_range(0, 1)) : (rsp_mode == 1);
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] ref_mem [2048];
    logic [31:0] exp_q[$];
    int          pop_cycles[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] last_rsp = '0;
    int acc_cnt = 0, wr_cnt = 0, busy_cnt = 0, rv_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    always @(negedge clk) begin
        if (!sram_cen) acc_cnt++;
        if (!sram_cen && !sram_wen) wr_cnt++;
        if (!rst && !req_ready) busy_cnt++;
        if (rsp_valid) rv_cnt++;
        if (rsp_valid && rsp_ready) begin
            pop_cycles.push_back(cyc);
            last_rsp = rsp_rdata;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rsp_unexpected: got %0h expected no response", rsp_rdata);
            end else begin
                check("rsp_data", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request, wait (bounded) for acceptance, update the reference at acceptance.
    task automatic issue(input logic we, input logic [10:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("req_accept", req_ready, 1);
        if (req_ready) begin
            if (we) ref_mem[a] = apply_be(ref_mem[a], wd, be);
            else    exp_q.push_back(ref_mem[a]);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic [10:0] addr;
        logic [31:0] prior;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_word;
        int          exp_acc;
        int          exp_wr;
        int          exp_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int a0, w0, b0, r0, p0, t0;

        vecs[0] = '{11'h00F, 32'h0000_0000, 32'h0000_000E, 4'hF, 32'h0000_000E, 1, 1, 0};
        vecs[1] = '{11'h010, 32'hAABB_CCDD, 32'h1122_3344, 4'h5, 32'hAA22_CC44, 2, 1, 1};
        vecs[2] = '{11'h020, 32'h1234_5678, 32'hDEAD_BEEF, 4'h0, 32'h1234_5678, 0, 0, 0};
        vecs[3] = '{11'h030, 32'hFFFF_FFFF, 32'h0000_0000, 4'h1, 32'hFFFF_FF00, 2, 1, 1};
        vecs[4] = '{11'h7FF, 32'h0123_4567, 32'h89AB_CDEF, 4'h8, 32'h8923_4567, 2, 1, 1};
        vecs[5] = '{11'h000, 32'h5555_5555, 32'hAAAA_AAAA, 4'h6, 32'h55AA_AA55, 2, 1, 1};

        for (int i = 0; i < 2048; i++) begin
            macro_mem[i] = 32'(i) * 32'h9E37_79B9;
            ref_mem[i]   = 32'(i) * 32'h9E37_79B9;
        end

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cen", sram_cen, 1);
        check("rst_wen", sram_wen, 1);
        check("sram_ema", sram_ema, 3'b000);
        check("sram_retn", sram_retn, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);
        check("post_rst_state", dbg_state, 0);
        check("post_rst_cen", sram_cen, 1);
        idle(1);

        // Table of write/readback vectors: full, partial (RMW) and empty byte enables
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, vecs[i].addr, vecs[i].prior, 4'hF);
            idle(2);
            a0 = acc_cnt; w0 = wr_cnt; b0 = busy_cnt;
            issue(1'b1, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            idle(3);
            check("vec_sram_access", acc_cnt - a0, vecs[i].exp_acc);
            check("vec_sram_write", wr_cnt - w0, vecs[i].exp_wr);
            check("vec_busy_cycles", busy_cnt - b0, vecs[i].exp_busy);
            r0 = rv_cnt;
            issue(1'b0, vecs[i].addr, '0, '0);
            idle(4);
            check("vec_rsp_cycles", rv_cnt - r0, 1);
            check("vec_word", last_rsp, vecs[i].exp_word);
        end

        // Backpressure: two reads fill the FIFO, the third waits for a pop
        rsp_mode = 0;
        idle(2);
        issue(1'b0, 11'h001, '0, '0);
        issue(1'b0, 11'h002, '0, '0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h003;
        repeat (3) begin
            @(negedge clk);
            check("bp_stall", req_ready, 0);
        end
        check("bp_rsp_waiting", rsp_valid, 1);
        rsp_mode = 1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_pop", rsp_valid && rsp_ready, 1);
        check("bp_release_ready", req_ready, 1);
        exp_q.push_back(ref_mem[3]);
        @(posedge clk);
        #1 req_valid = 1'b0;
        idle(6);
        check("bp_drained", exp_q.size(), 0);

        // Streaming reads: one accept per cycle, gap-free responses
        p0 = pop_cycles.size();
        t0 = cyc;
        for (int i = 0; i < 8; i++) issue(1'b0, 11'(i), '0, '0);
        check("stream_accept_cycles", cyc - t0, 8);
        idle(5);
        check("stream_rsp_count", pop_cycles.size() - p0, 8);
        check("stream_rsp_span", pop_cycles[p0 + 7] - pop_cycles[p0], 7);

        // Reset during the RMW read cycle abandons the write
        issue(1'b1, 11'h040, 32'hCAFE_F00D, 4'hF);
        idle(2);
        w0 = wr_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h040;
        req_wdata = 32'h1111_1111; req_be = 4'h3;
        @(negedge clk);
        check("rmw_rst_accept", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rmw_rst_wen", sram_wen, 1);
            check("rmw_rst_cen", sram_cen, 1);
            check("rmw_rst_ready", req_ready, 0);
            check("rmw_rst_rsp_valid", rsp_valid, 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        check("rmw_rst_no_write", wr_cnt - w0, 0);
        idle(1);
        issue(1'b0, 11'h040, '0, '0);
        idle(4);
        check("rmw_rst_word", last_rsp, 32'hCAFE_F00D);

        // Randomized traffic with random response backpressure
        rsp_mode = 2;
        idle(2);
        for (int i = 0; i < 300; i++) begin
            logic        we;
            logic [3:0]  be;
            int          sel;
            we  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            be  = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(1, 14));
            issue(we, 11'($urandom_range(0, 15)), $urandom, be);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        rsp_mode = 1;
        idle(3);
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("final_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
